pipe_regalu: RTL

- Pipelined, parametrised successor to the single-cycle register/ALU/data-memory datapath.
- Accepts one decoded instruction per cycle. Control signals are the same kind the decoder already produces, with a 2-bit result select that replaces the separate jal mux.
- Two internal stages:
  - E: register read, forwarding, ALU, eq.
  - W: data memory access, result select, register writeback.
- Adds a stall/flush handshake and a retired-instruction counter. Sits between the decoder/PC logic and the top level.

---
 rtl/pipe_regalu.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_regalu.sv
// Two-stage register/ALU/data-memory datapath: E (read, forward, ALU) then W (memory, writeback).
// Accepts one decoded instruction per cycle under a stall/flush handshake and counts retirements.
module pipe_regalu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 5,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int PC_WIDTH       = 32,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    input  logic                     RegWrite,
    input  logic                     ALUsrc,
    input  logic [1:0]               ResultSrc,
    input  logic                     MemWrite,
    input  logic [2:0]               ALUCtrl,
    input  logic [DATA_WIDTH-1:0]    ImmOp,
    input  logic [PC_WIDTH-1:0]      PC,
    output logic                     eq,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic [CNT_WIDTH-1:0]     retired
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int NREG    = 2**ADDRESS_WIDTH;
    localparam int NMEM    = 2**MEM_ADDR_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rs1;
        logic [ADDRESS_WIDTH-1:0] rs2;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic                     reg_write;
        logic                     alu_src;
        logic [1:0]               result_src;
        logic                     mem_write;
        logic [2:0]               alu_ctrl;
        logic [DATA_WIDTH-1:0]    imm;
        logic [PC_WIDTH-1:0]      pc;
    } e_pkt_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    alu;
        logic [DATA_WIDTH-1:0]    store;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic                     reg_write;
        logic                     mem_write;
        logic [1:0]               result_src;
        logic [DATA_WIDTH-1:0]    imm;
        logic [PC_WIDTH-1:0]      pc;
    } w_pkt_t;

    function automatic logic [DATA_WIDTH-1:0] alu_op(input logic [2:0] ctrl,
                                                     input logic signed [DATA_WIDTH-1:0] a,
                                                     input logic signed [DATA_WIDTH-1:0] b);
        logic [SHAMT_W-1:0]    sh;
        logic [DATA_WIDTH-1:0] r;
        sh = b[SHAMT_W-1:0];
        case (ctrl)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            3'b110:  r = $unsigned(a) << sh;
            default: r = $unsigned(a) >> sh;
        endcase
        return r;
    endfunction

    logic                     vld_p1_q, vld_p1_d;
    e_pkt_t                   e_p1_q, e_p1_d;
    logic                     vld_p2_q, vld_p2_d;
    w_pkt_t                   w_p2_q, w_p2_d;
    logic [CNT_WIDTH-1:0]     retired_q, retired_d;
    logic [DATA_WIDTH-1:0]    rf_q [NREG];
    logic [DATA_WIDTH-1:0]    mem_q [NMEM];

    logic signed [DATA_WIDTH-1:0] op1_p1, op2_p1;
    logic [DATA_WIDTH-1:0]        rs2_val_p1;
    logic [MEM_ADDR_WIDTH-1:0]    mem_idx_p2;
    logic [PC_WIDTH-1:0]          pc4_p2;
    logic [DATA_WIDTH-1:0]        result_p2;
    logic                         wr_en_p2;
    logic                         unused_alu_bits;

    assign in_ready = ~stall & ~flush;

    // Input capture into E
    always_comb begin
        vld_p1_d = vld_p1_q;
        e_p1_d   = e_p1_q;
        if (flush) begin
            vld_p1_d = 1'b0;
        end else if (!stall) begin
            vld_p1_d          = in_valid;
            e_p1_d.rs1        = rs1;
            e_p1_d.rs2        = rs2;
            e_p1_d.rd         = rd;
            e_p1_d.reg_write  = RegWrite;
            e_p1_d.alu_src    = ALUsrc;
            e_p1_d.result_src = ResultSrc;
            e_p1_d.mem_write  = MemWrite;
            e_p1_d.alu_ctrl   = ALUCtrl;
            e_p1_d.imm        = ImmOp;
            e_p1_d.pc         = PC;
        end
    end

    // E stage: register read with W-to-E forwarding; x0 is never written so it reads 0
    always_comb begin
        op1_p1     = rf_q[e_p1_q.rs1];
        rs2_val_p1 = rf_q[e_p1_q.rs2];
        if (wr_en_p2 && (w_p2_q.rd == e_p1_q.rs1)) op1_p1 = result_p2;
        if (wr_en_p2 && (w_p2_q.rd == e_p1_q.rs2)) rs2_val_p1 = result_p2;
        op2_p1 = e_p1_q.alu_src ? e_p1_q.imm : rs2_val_p1;
    end

    assign eq = vld_p1_q & (op1_p1 == op2_p1);

    // E -> W transfer
    always_comb begin
        vld_p2_d          = vld_p1_q & ~stall & ~flush;
        w_p2_d.alu        = alu_op(e_p1_q.alu_ctrl, op1_p1, op2_p1);
        w_p2_d.store      = rs2_val_p1;
        w_p2_d.rd         = e_p1_q.rd;
        w_p2_d.reg_write  = e_p1_q.reg_write;
        w_p2_d.mem_write  = e_p1_q.mem_write;
        w_p2_d.result_src = e_p1_q.result_src;
        w_p2_d.imm        = e_p1_q.imm;
        w_p2_d.pc         = e_p1_q.pc;
    end

    // W stage: word-addressed memory (byte offset and upper bits dropped), result select
    assign mem_idx_p2      = w_p2_q.alu[MEM_ADDR_WIDTH+1:2];
    assign unused_alu_bits = ^{w_p2_q.alu[DATA_WIDTH-1:MEM_ADDR_WIDTH+2], w_p2_q.alu[1:0]};
    assign pc4_p2          = w_p2_q.pc + PC_WIDTH'(4);
    assign wr_en_p2        = vld_p2_q & w_p2_q.reg_write & (w_p2_q.rd != '0);

    always_comb begin
        case (w_p2_q.result_src)
            2'b00:   result_p2 = w_p2_q.alu;
            2'b01:   result_p2 = mem_q[mem_idx_p2];
            2'b10:   result_p2 = DATA_WIDTH'(pc4_p2);
            default: result_p2 = w_p2_q.imm;
        endcase
    end

    always_comb begin
        retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, vld_p2_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            retired_q <= retired_d;
        end
    end

    always_ff @(posedge clk) begin
        e_p1_q <= e_p1_d;
        w_p2_q <= w_p2_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wr_en_p2) begin
            rf_q[w_p2_q.rd] <= result_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && vld_p2_q && w_p2_q.mem_write) mem_q[mem_idx_p2] <= w_p2_q.store;
    end

    assign a0      = rf_q[A0_IDX];
    assign retired = retired_q;

endmodule
